// File: rtl/axi_reg_arbiter.sv
// Round-robin arbiter that serialises single-word read/write commands from two requesters onto an AXI register slave.
// Latency: accept T0, AW/W or AR at T1, B or R at T2, response pulse at T3 (minimum 4 cycles per transaction).
// Backpressure: one transaction in flight; commands wait in IDLE, AXI channels hold valid until the slave handshakes.
module axi_reg_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [1:0]            req_we_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [2*DATA_W-1:0]   req_wdata_i,
    input  logic [2*DATA_W/8-1:0] req_wstrb_i,
    output logic [1:0]            rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic [ID_W-1:0]       awid_o,
    output logic [ADDR_W-1:0]     awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic [ID_W-1:0]       arid_o,
    output logic [ADDR_W-1:0]     araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rvalid_i,
    output logic                  rready_o
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, RESP} state_t;

    state_t              state_q;
    logic                last_q;
    logic                gnt_q;
    logic [ID_W-1:0]     awid_q, arid_q;
    logic [ADDR_W-1:0]   awaddr_q, araddr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [1:0]          rsp_valid_q;
    logic                err_q;

    logic                gnt_d;
    logic                accept;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;
    logic                aw_left, w_left;

    // Grant choice and request-slice selection; ready is a same-cycle pulse while idle and out of reset
    always_comb begin
        gnt_d       = (req_valid_i == 2'b11) ? ~last_q : req_valid_i[1];
        accept      = areset && (state_q == IDLE) && (req_valid_i != 2'b00);
        req_ready_o = accept ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
        sel_we      = gnt_d ? req_we_i[1] : req_we_i[0];
        sel_addr    = gnt_d ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
        sel_wdata   = gnt_d ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
        sel_wstrb   = gnt_d ? req_wstrb_i[2*STRB_W-1:STRB_W] : req_wstrb_i[STRB_W-1:0];
        // A channel still owes a handshake if its valid is up and the slave is not taking it this cycle
        aw_left     = awvalid_q && !awready_i;
        w_left      = wvalid_q && !wready_i;
    end

    // Sequencer: accepts one command, walks the AXI handshakes, then pulses the response
    always_ff @(posedge clk) begin
        if (!areset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            awid_q      <= '0;
            arid_q      <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        gnt_q  <= gnt_d;
                        last_q <= gnt_d;
                        if (sel_we) begin
                            awid_q    <= ID_W'(gnt_d);
                            awaddr_q  <= sel_addr;
                            wdata_q   <= sel_wdata;
                            wstrb_q   <= sel_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR;
                        end else begin
                            arid_q    <= ID_W'(gnt_d);
                            araddr_q  <= sel_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= RD;
                        end
                    end
                end
                WR: begin
                    // AW and W retire independently; move on once neither is pending
                    awvalid_q <= aw_left;
                    wvalid_q  <= w_left;
                    if (!aw_left && !w_left) begin
                        bready_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid_i) begin
                        err_q       <= (bresp_i != 2'b00);
                        bready_q    <= 1'b0;
                        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end
                end
                RD: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid_i) begin
                        rdata_q     <= rdata_i;
                        err_q       <= (rresp_i != 2'b00);
                        rready_q    <= 1'b0;
                        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 2'b00;
                    err_q       <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign awid_o      = awid_q;
    assign awaddr_o    = awaddr_q;
    assign awvalid_o   = awvalid_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign wvalid_o    = wvalid_q;
    assign bready_o    = bready_q;
    assign arid_o      = arid_q;
    assign araddr_o    = araddr_q;
    assign arvalid_o   = arvalid_q;
    assign rready_o    = rready_q;

endmodule

// File: tb/tb_axi_reg_arbiter.sv
// Bench for axi_reg_arbiter: behavioural AXI slave with programmable ready delays and response codes.
// Expected responses are queued at command acceptance and compared when the response pulse appears.
// Table of command vectors plus hand sequences for slow AW, and reset during the write response.
module tb_axi_reg_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic              clk = 1'b0;
    logic              areset;
    logic [1:0]        req_valid_i, req_ready_o, req_we_i;
    logic [63:0]       req_addr_i, req_wdata_i;
    logic [7:0]        req_wstrb_i;
    logic [1:0]        rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o, busy_o;
    logic [ID_W-1:0]   awid_o, arid_o;
    logic [31:0]       awaddr_o, araddr_o, wdata_o, rdata_i;
    logic [3:0]        wstrb_o;
    logic              awvalid_o, awready_i, wvalid_o, wready_i;
    logic [1:0]        bresp_i, rresp_i;
    logic              bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;

    always #5 clk = ~clk;

    axi_reg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .areset(areset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    int          aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
    bit          b_hold = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          aw_done, w_done, b_fire, ar_done, r_fire, mem_init = 0;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [16];

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] = 32'h0;
            mem_init = 1;
        end
        if (areset !== 1'b1) begin
            awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
            arready_i = 0; rvalid_i = 0; rresp_i = 0; rdata_i = 0;
            aw_done = 0; w_done = 0; b_fire = 0; ar_done = 0; r_fire = 0;
            aw_cnt = 0; w_cnt = 0;
        end else begin
            if (b_fire) begin
                bvalid_i = 0; b_fire = 0;
            end else if (aw_done && w_done && !b_hold && !bvalid_i) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[s_awaddr[3:0]][8*b +: 8] = s_wdata[8*b +: 8];
                bvalid_i = 1; bresp_i = bresp_cfg; aw_done = 0; w_done = 0;
            end
            b_fire = bvalid_i && bready_o;
            if (r_fire) begin
                rvalid_i = 0; r_fire = 0;
            end else if (ar_done && !rvalid_i) begin
                rvalid_i = 1; rresp_i = rresp_cfg; rdata_i = mem[s_araddr[3:0]]; ar_done = 0;
            end
            r_fire = rvalid_i && rready_o;
            awready_i = awvalid_o && (aw_cnt >= aw_dly);
            if (awvalid_o && !awready_i) aw_cnt++; else aw_cnt = 0;
            if (awvalid_o && awready_i) begin aw_done = 1; s_awaddr = awaddr_o; end
            wready_i = wvalid_o && (w_cnt >= w_dly);
            if (wvalid_o && !wready_i) w_cnt++; else w_cnt = 0;
            if (wvalid_o && wready_i) begin w_done = 1; s_wdata = wdata_o; s_wstrb = wstrb_o; end
            arready_i = arvalid_o;
            if (arvalid_o) begin ar_done = 1; s_araddr = araddr_o; end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          g;
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc = 0;
    int   rsp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rsp_valid_o !== 2'b00) begin
            if (sbq.size() == 0) begin
                check("spurious_rsp", {62'b0, rsp_valid_o}, 64'h0);
            end else begin
                e = sbq.pop_front();
                check("rsp_who", {62'b0, rsp_valid_o}, (e.g != 0) ? 64'h2 : 64'h1);
                check("rsp_err", {63'b0, rsp_err_o}, {63'b0, e.err});
                check("rsp_rdata", {32'b0, rsp_rdata_o}, {32'b0, e.rdata});
                check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
            end
            rsp_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic [1:0]  valid, we;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  s0, s1;
        logic [1:0]  bresp, rresp;
        int          g;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt[11];
    vec_t hv;

    task automatic drive(input vec_t v);
        req_valid_i = v.valid;
        req_we_i    = v.we;
        req_addr_i  = {v.a1, v.a0};
        req_wdata_i = {v.d1, v.d0};
        req_wstrb_i = {v.s1, v.s0};
        bresp_cfg   = v.bresp;
        rresp_cfg   = v.rresp;
        #1;
    endtask

    task automatic wait_accept(input int exp_g, input bit exp_we, input bit push,
                               input logic exp_err, input logic [31:0] exp_rdata, input int lat);
        bit         got = 0;
        logic [1:0] oh = (exp_g == 1) ? 2'b10 : 2'b01;
        exp_t       t;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req_ready_o !== 2'b00) got = 1;
            else begin @(negedge clk); #1; end
        end
        if (!got) begin
            check("accept_timeout", {62'b0, req_ready_o}, {62'b0, oh});
            return;
        end
        check("grant", {62'b0, req_ready_o}, {62'b0, oh});
        check("busy_at_accept", {63'b0, busy_o}, 64'h0);
        if (push) begin
            t.g = exp_g; t.err = exp_err; t.rdata = exp_rdata; t.acc = cyc; t.lat = lat;
            sbq.push_back(t);
        end
        @(negedge clk); #1;
        if (exp_we) begin
            check("aw_w_valid_T1", {62'b0, awvalid_o, wvalid_o}, 64'h3);
            check("awid", {60'b0, awid_o}, 64'(exp_g));
        end else begin
            check("arvalid_T1", {63'b0, arvalid_o}, 64'h1);
            check("arid", {60'b0, arid_o}, 64'(exp_g));
        end
        check("busy_T1", {63'b0, busy_o}, 64'h1);
    endtask

    task automatic wait_rsp(input int target);
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); #1;
            if (rsp_cnt >= target) got = 1;
        end
        if (!got) check("rsp_timeout", 64'(rsp_cnt), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [2:0] dly_seq [4];
        bit         got;

        areset = 1'b0; req_valid_i = 2'b11; req_we_i = 2'b11;
        req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;

        // Reset held for three clocks with both requesters asking
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_ready", {62'b0, req_ready_o}, 64'h0);
        end
        check("rst_busy", {63'b0, busy_o}, 64'h0);
        check("rst_valids", {59'b0, awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}, 64'h0);
        check("rst_rsp", {61'b0, rsp_valid_o, rsp_err_o}, 64'h0);
        check("rst_rdata", {32'b0, rsp_rdata_o}, 64'h0);
        check("rst_addr", {awaddr_o, araddr_o}, 64'h0);
        check("rst_wdata", {28'b0, wstrb_o, wdata_o}, 64'h0);
        check("rst_ids", {56'b0, awid_o, arid_o}, 64'h0);
        #1;
        req_valid_i = 2'b00;
        areset = 1'b1;
        @(negedge clk); #1;

        //            valid  we     a0     a1     d0            d1            s0    s1    bresp  rresp  g  err   rdata
        vt[0]  = '{2'b01, 2'b01, 32'd1, 32'd0, 32'hC2AAEE2A, 32'h0,        4'hF, 4'h0, 2'b00, 2'b00, 0, 1'b0, 32'h0};
        vt[1]  = '{2'b01, 2'b01, 32'd2, 32'd0, 32'h7778111A, 32'h0,        4'hF, 4'h0, 2'b00, 2'b00, 0, 1'b0, 32'h0};
        vt[2]  = '{2'b11, 2'b01, 32'd2, 32'd2, 32'h7778111A, 32'h0,        4'hF, 4'h0, 2'b00, 2'b00, 1, 1'b0, 32'h7778111A};
        vt[3]  = '{2'b11, 2'b01, 32'd2, 32'd2, 32'h7778111A, 32'h0,        4'hF, 4'h0, 2'b00, 2'b00, 0, 1'b0, 32'h7778111A};
        vt[4]  = '{2'b11, 2'b01, 32'd2, 32'd2, 32'h7778111A, 32'h0,        4'hF, 4'h0, 2'b00, 2'b00, 1, 1'b0, 32'h7778111A};
        vt[5]  = '{2'b10, 2'b10, 32'd0, 32'd3, 32'h0,        32'h11223344, 4'h0, 4'h3, 2'b00, 2'b00, 1, 1'b0, 32'h7778111A};
        vt[6]  = '{2'b11, 2'b00, 32'd3, 32'd1, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 0, 1'b0, 32'h00003344};
        vt[7]  = '{2'b11, 2'b00, 32'd3, 32'd1, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 1, 1'b0, 32'hC2AAEE2A};
        vt[8]  = '{2'b01, 2'b01, 32'd4, 32'd0, 32'hDEADBEEF, 32'h0,        4'hF, 4'h0, 2'b10, 2'b00, 0, 1'b1, 32'hC2AAEE2A};
        vt[9]  = '{2'b10, 2'b00, 32'd0, 32'd4, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 1, 1'b0, 32'hDEADBEEF};
        vt[10] = '{2'b10, 2'b00, 32'd0, 32'd4, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b10, 1, 1'b1, 32'hDEADBEEF};

        for (int i = 0; i < 11; i++) begin
            drive(vt[i]);
            wait_accept(vt[i].g, vt[i].we[vt[i].g], 1'b1, vt[i].err, vt[i].rdata, 3);
            wait_rsp(i + 1);
        end
        req_valid_i = 2'b00;

        // Slow AW: W taken immediately, AW three cycles later
        aw_dly = 3; w_dly = 0;
        hv = '{2'b01, 2'b01, 32'd5, 32'd0, 32'h0A0B0C0D, 32'h0, 4'hF, 4'h0, 2'b00, 2'b00, 0, 1'b0, 32'hDEADBEEF};
        drive(hv);
        wait_accept(0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 6);
        req_valid_i = 2'b00;
        dly_seq[0] = 3'b100; dly_seq[1] = 3'b100; dly_seq[2] = 3'b100; dly_seq[3] = 3'b001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("slow_aw_seq", {61'b0, awvalid_o, wvalid_o, bready_o}, {61'b0, dly_seq[k]});
            if (k < 3) check("slow_aw_addr_stable", {32'b0, awaddr_o}, 64'd5);
        end
        wait_rsp(12);
        aw_dly = 0;

        // Reset while waiting for a write response that never comes
        b_hold = 1;
        hv = '{2'b01, 2'b01, 32'd6, 32'd0, 32'h12345678, 32'h0, 4'hF, 4'h0, 2'b00, 2'b00, 0, 1'b0, 32'h0};
        drive(hv);
        wait_accept(0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
        req_valid_i = 2'b00;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); #1;
            if (bready_o === 1'b1) got = 1;
        end
        check("wresp_reached", {63'b0, bready_o}, 64'h1);
        check("wresp_busy", {63'b0, busy_o}, 64'h1);
        areset = 1'b0;
        hv = '{2'b11, 2'b00, 32'd1, 32'd1, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b00, 0, 1'b0, 32'h0};
        drive(hv);
        @(negedge clk); #1;
        check("abort_bready", {63'b0, bready_o}, 64'h0);
        check("abort_busy", {63'b0, busy_o}, 64'h0);
        check("abort_rsp", {62'b0, rsp_valid_o}, 64'h0);
        check("abort_req_ready", {62'b0, req_ready_o}, 64'h0);
        areset = 1'b1;
        b_hold = 0;
        #1;
        wait_accept(0, 1'b0, 1'b1, 1'b0, 32'hC2AAEE2A, 3);
        req_valid_i = 2'b00;
        wait_rsp(13);

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(sbq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
